synchronous_fifo: RTL and testbench

Single-clock, parameterised first-in/first-out buffer with separate write and read enables and full/empty status flags. It decouples a producer and consumer running on the same clock. It sits behind the `fifo_intf` interface and is driven by the `fifo_test` bench.

---
 rtl/synchronous_fifo_pkg.sv | 5 +
 rtl/synchronous_fifo_mem.sv | 37 +++
 rtl/synchronous_fifo.sv | 64 ++++++
 tb/tb_synchronous_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/synchronous_fifo_pkg.sv
// Default geometry shared by the FIFO top and its storage array.
package synchronous_fifo_pkg;
   localparam int DEFAULT_DEPTH      = 32;
   localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/synchronous_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port.
// Read data is valid after the edge that samples re; it holds when re is low.
import synchronous_fifo_pkg::*;

module synchronous_fifo_mem #(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with wrap-bit pointers; 1-cycle registered read, no fall-through.
// Writes when full and reads when empty are silently dropped.
import synchronous_fifo_pkg::*;

module synchronous_fifo #(
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          wr_ok;
   logic          rd_ok;

   // Equal low bits with differing wrap bits means the writer is a full lap ahead.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

   assign wr_ok = w_en && !full;
   assign rd_ok = r_en && !empty;

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + PW'(1);
         end
         if (rd_ok) begin
            rptr <= rptr + PW'(1);
         end
      end
   end

   synchronous_fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (AW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst_n),
      .we    (wr_ok),
      .waddr (wptr[AW-1:0]),
      .wdata (data_in),
      .re    (rd_ok),
      .raddr (rptr[AW-1:0]),
      .rdata (data_out)
   );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Directed bench for synchronous_fifo at the default 32 x 8 geometry.
module tb_synchronous_fifo;

   logic       clk;
   logic       rst_n;
   logic       w_en;
   logic       r_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int checks;
   int failures;

   synchronous_fifo #(.DEPTH(32), .DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs are driven after this point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      data_in = 8'h00;
      step();
      step();
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
      w_en = 1'b1;
      data_in = 8'h55;
      step();
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL reset_hold_write got_empty=%b exp=1", empty); end
      w_en = 1'b0;
      rst_n = 1'b0;
      step();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) begin
         w_en = 1'b1;
         data_in = 8'(i);
         step();
         checks++;
         if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty idx=%0d got=%b exp=0", i, empty); end
         checks++;
         if (full !== (i == 31)) begin failures++; $display("FAIL fill_full idx=%0d got=%b exp=%b", i, full, (i == 31)); end
      end
      data_in = 8'hAA;
      step();
      checks++;
      if (full !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", full); end
      w_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         r_en = 1'b1;
         step();
         checks++;
         if (data_out !== 8'(i)) begin failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, data_out, 8'(i)); end
         checks++;
         if (empty !== (i == 31)) begin failures++; $display("FAIL drain_empty idx=%0d got=%b exp=%b", i, empty, (i == 31)); end
      end
      r_en = 1'b0;
   endtask

   task automatic test_underflow();
      r_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (data_out !== 8'h1F) begin failures++; $display("FAIL underflow_data got=%h exp=1f", data_out); end
         checks++;
         if (empty !== 1'b1) begin failures++; $display("FAIL underflow_empty got=%b exp=1", empty); end
      end
      r_en = 1'b0;
      w_en = 1'b1;
      data_in = 8'h77;
      step();
      w_en = 1'b0;
      checks++;
      if (empty !== 1'b0) begin failures++; $display("FAIL underflow_after_write got_empty=%b exp=0", empty); end
      r_en = 1'b1;
      step();
      r_en = 1'b0;
      checks++;
      if (data_out !== 8'h77) begin failures++; $display("FAIL underflow_after_read got=%h exp=77", data_out); end
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL underflow_after_read_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] exp;
      for (int i = 0; i < 5; i++) begin
         w_en = 1'b1;
         data_in = 8'h10 + 8'(i);
         step();
      end
      r_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         data_in = 8'h20 + 8'(k);
         step();
         exp = (k < 5) ? 8'h10 + 8'(k) : 8'h20 + 8'(k - 5);
         checks++;
         if (data_out !== exp) begin failures++; $display("FAIL simul_data k=%0d got=%h exp=%h", k, data_out, exp); end
         checks++;
         if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL simul_flags k=%0d got_empty=%b got_full=%b exp=0/0", k, empty, full); end
      end
      r_en = 1'b0;
      // 5 stored (0x25..0x29); top up to 32 with 0x40..0x5A.
      for (int j = 0; j < 27; j++) begin
         data_in = 8'h40 + 8'(j);
         step();
      end
      checks++;
      if (full !== 1'b1) begin failures++; $display("FAIL simul_topup_full got=%b exp=1", full); end
      r_en = 1'b1;
      data_in = 8'hBB;
      step();
      w_en = 1'b0;
      checks++;
      if (data_out !== 8'h25) begin failures++; $display("FAIL simul_full_data got=%h exp=25", data_out); end
      checks++;
      if (full !== 1'b0) begin failures++; $display("FAIL simul_full_flag got=%b exp=0", full); end
      for (int j = 0; j < 31; j++) begin
         step();
         exp = (j < 4) ? 8'h26 + 8'(j) : 8'h40 + 8'(j - 4);
         checks++;
         if (data_out !== exp) begin failures++; $display("FAIL simul_drain j=%0d got=%h exp=%h", j, data_out, exp); end
      end
      r_en = 1'b0;
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL simul_drain_empty got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      logic [7:0] sb [32];
      for (int r = 0; r < 3; r++) begin
         w_en = 1'b1;
         for (int i = 0; i < 32; i++) begin
            sb[i] = 8'($urandom_range(0, 255));
            data_in = sb[i];
            step();
         end
         w_en = 1'b0;
         checks++;
         if (full !== 1'b1) begin failures++; $display("FAIL wrap_full round=%0d got=%b exp=1", r, full); end
         r_en = 1'b1;
         for (int i = 0; i < 32; i++) begin
            step();
            checks++;
            if (data_out !== sb[i]) begin failures++; $display("FAIL wrap_data round=%0d idx=%0d got=%h exp=%h", r, i, data_out, sb[i]); end
         end
         r_en = 1'b0;
         checks++;
         if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty round=%0d got=%b exp=1", r, empty); end
      end
   endtask

   task automatic test_async_reset();
      w_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 8'h60 + 8'(i);
         step();
      end
      w_en = 1'b0;
      r_en = 1'b1;
      step();
      r_en = 1'b0;
      checks++;
      if (data_out !== 8'h60) begin failures++; $display("FAIL async_pre_read got=%h exp=60", data_out); end
      #2;
      rst_n = 1'b1;
      #1;
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL async_empty got=%b exp=1", empty); end
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL async_data got=%h exp=00", data_out); end
      rst_n = 1'b0;
      r_en = 1'b1;
      step();
      r_en = 1'b0;
      checks++;
      if (data_out !== 8'h00) begin failures++; $display("FAIL async_read_after got=%h exp=00", data_out); end
      checks++;
      if (empty !== 1'b1) begin failures++; $display("FAIL async_read_after_empty got=%b exp=1", empty); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_fill();
      test_underflow();
      test_simultaneous();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
